// File: rtl/bno055_txn_arbiter.sv
// Round-robin arbiter that serialises up to three register-access
// requesters onto one BNO055 I2C engine. Each transaction is followed
// by an enforced idle gap so that a mode switch on the sensor has time
// to settle before the next access.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transaction; arbitrate among pending requests
// ISSUE | one-cycle opcode strobe (READ or WRITE) to the engine
// WAIT  | waiting for the engine's i_op_done, bounded by the timeout
// GAP   | post-transaction settling time before the next arbitration
module bno055_txn_arbiter #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2500000,
    parameter logic [23:0] GAP_CYCLES     = 24'd175000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [2:0]  i_req,
    input  logic [2:0]  i_req_wr,
    input  logic [23:0] i_req_addr,
    input  logic [23:0] i_req_data,
    input  logic        i_op_done,
    input  logic [7:0]  i_rd_data,
    output logic [2:0]  o_grant,
    output logic [2:0]  o_done,
    output logic [2:0]  o_err,
    output logic [7:0]  o_rd_data,
    output logic        o_busy,
    output logic [1:0]  o_opcode,
    output logic [7:0]  o_reg_addr,
    output logic [7:0]  o_tx_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [1:0] OP_STOP  = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    state_t      state, state_nxt;
    logic [23:0] cnt, cnt_nxt;
    logic [1:0]  rr_ptr, rr_ptr_nxt;
    logic        wr_q, wr_nxt;

    logic [2:0]  grant_nxt, done_nxt, err_nxt;
    logic [7:0]  rd_data_nxt, reg_addr_nxt, tx_data_nxt;
    logic [1:0]  opcode_nxt;
    logic        busy_nxt;

    logic        win_vld;
    logic [1:0]  win_idx;
    logic [2:0]  cand_sum;
    logic [7:0]  win_addr, win_data;
    logic        win_wr;

    logic        timeout_hit, gap_hit;

    // Terminal counts are compared as cnt+1 >= limit so a limit of zero
    // fires on the first cycle instead of wrapping around.
    assign timeout_hit = ({1'b0, cnt} + 25'd1) >= {1'b0, TIMEOUT_CYCLES};
    assign gap_hit     = ({1'b0, cnt} + 25'd1) >= {1'b0, GAP_CYCLES};

    // Round-robin search: scan offsets high to low so the nearest set
    // request at or after rr_ptr is the last one written and wins.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = 2'd0;
        cand_sum = 3'd0;
        for (int off = 2; off >= 0; off--) begin
            cand_sum = {1'b0, rr_ptr} + 3'(off);
            if (cand_sum >= 3'd3) begin
                cand_sum = cand_sum - 3'd3;
            end
            if (i_req[cand_sum[1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand_sum[1:0];
            end
        end
    end

    // Select the winning requester's address, data and direction.
    always_comb begin
        win_addr = i_req_addr[7:0];
        win_data = i_req_data[7:0];
        win_wr   = i_req_wr[0];
        case (win_idx)
            2'd1: begin
                win_addr = i_req_addr[15:8];
                win_data = i_req_data[15:8];
                win_wr   = i_req_wr[1];
            end
            2'd2: begin
                win_addr = i_req_addr[23:16];
                win_data = i_req_data[23:16];
                win_wr   = i_req_wr[2];
            end
            default: ;
        endcase
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        rr_ptr_nxt   = rr_ptr;
        wr_nxt       = wr_q;
        grant_nxt    = o_grant;
        done_nxt     = 3'b000;
        err_nxt      = 3'b000;
        opcode_nxt   = OP_STOP;
        rd_data_nxt  = o_rd_data;
        reg_addr_nxt = o_reg_addr;
        tx_data_nxt  = o_tx_data;

        case (state)
            ST_IDLE: begin
                if (win_vld) begin
                    reg_addr_nxt = win_addr;
                    tx_data_nxt  = win_data;
                    wr_nxt       = win_wr;
                    grant_nxt    = 3'b001 << win_idx;
                    opcode_nxt   = win_wr ? OP_WRITE : OP_READ;
                    rr_ptr_nxt   = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
                    cnt_nxt      = 24'd0;
                    state_nxt    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_nxt   = 24'd0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion takes priority over a coincident timeout.
                if (i_op_done) begin
                    done_nxt  = o_grant;
                    grant_nxt = 3'b000;
                    if (!wr_q) begin
                        rd_data_nxt = i_rd_data;
                    end
                    cnt_nxt   = 24'd0;
                    state_nxt = ST_GAP;
                end else if (timeout_hit) begin
                    err_nxt   = o_grant;
                    grant_nxt = 3'b000;
                    cnt_nxt   = 24'd0;
                    state_nxt = ST_GAP;
                end else begin
                    cnt_nxt = cnt + 24'd1;
                end
            end
            ST_GAP: begin
                if (gap_hit) begin
                    cnt_nxt   = 24'd0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 24'd1;
                end
            end
            default: begin
                cnt_nxt   = 24'd0;
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter, arbitration pointer and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt        <= 24'd0;
            rr_ptr     <= 2'd0;
            wr_q       <= 1'b0;
            o_grant    <= 3'b000;
            o_done     <= 3'b000;
            o_err      <= 3'b000;
            o_opcode   <= OP_STOP;
            o_reg_addr <= 8'h00;
            o_tx_data  <= 8'h00;
            o_rd_data  <= 8'h00;
            o_busy     <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            rr_ptr     <= rr_ptr_nxt;
            wr_q       <= wr_nxt;
            o_grant    <= grant_nxt;
            o_done     <= done_nxt;
            o_err      <= err_nxt;
            o_opcode   <= opcode_nxt;
            o_reg_addr <= reg_addr_nxt;
            o_tx_data  <= tx_data_nxt;
            o_rd_data  <= rd_data_nxt;
            o_busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_bno055_txn_arbiter.sv
// Bench for bno055_txn_arbiter: the bench plays the requesters and the
// I2C engine, and predicts every transaction (winner, opcode, outcome,
// completion cycle, gap length) from a transaction-level model.
module tb_bno055_txn_arbiter;

    localparam int TO  = 20;
    localparam int GAP = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [2:0]  i_req = 3'b000;
    logic [2:0]  i_req_wr = 3'b000;
    logic [23:0] i_req_addr = 24'h0;
    logic [23:0] i_req_data = 24'h0;
    logic        i_op_done = 1'b0;
    logic [7:0]  i_rd_data = 8'h00;
    logic [2:0]  o_grant, o_done, o_err;
    logic [7:0]  o_rd_data, o_reg_addr, o_tx_data;
    logic        o_busy;
    logic [1:0]  o_opcode;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: round-robin pointer, last read value, requester payloads.
    int         m_ptr = 0;
    logic [7:0] m_rd = 8'h00;
    logic [7:0] r_addr [3];
    logic [7:0] r_data [3];
    logic       r_wr   [3];

    bno055_txn_arbiter #(
        .TIMEOUT_CYCLES(24'd20),
        .GAP_CYCLES    (24'd4)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (i_req),
        .i_req_wr  (i_req_wr),
        .i_req_addr(i_req_addr),
        .i_req_data(i_req_data),
        .i_op_done (i_op_done),
        .i_rd_data (i_rd_data),
        .o_grant   (o_grant),
        .o_done    (o_done),
        .o_err     (o_err),
        .o_rd_data (o_rd_data),
        .o_busy    (o_busy),
        .o_opcode  (o_opcode),
        .o_reg_addr(o_reg_addr),
        .o_tx_data (o_tx_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic new_req(input int k, input logic wr, input logic [7:0] a, input logic [7:0] d);
        r_wr[k]   = wr;
        r_addr[k] = a;
        r_data[k] = d;
        i_req[k]  = 1'b1;
        i_req_wr   = {r_wr[2], r_wr[1], r_wr[0]};
        i_req_addr = {r_addr[2], r_addr[1], r_addr[0]};
        i_req_data = {r_data[2], r_data[1], r_data[0]};
    endtask

    // Called at the falling edge of an IDLE cycle with requests driven;
    // returns at the falling edge of the next IDLE cycle. The engine
    // raises i_op_done in WAIT cycle jdone (1-based); jdone > TO means
    // no answer in time, and the late pulse lands inside the gap.
    task automatic do_txn(input int jdone, input logic [7:0] rdv, input bit hold);
        int k;
        int got_d;
        int exp_d;
        logic [2:0] kmask;
        k = -1;
        for (int off = 0; off < 3; off++) begin
            int c;
            c = (m_ptr + off) % 3;
            if (k < 0 && i_req[c]) k = c;
        end
        if (k < 0) k = 0;
        kmask = 3'b001 << k;
        @(negedge i_clk);
        check_eq("issue_grant",  {29'd0, o_grant}, {29'd0, kmask});
        check_eq("issue_opcode", {30'd0, o_opcode}, r_wr[k] ? 32'd2 : 32'd1);
        check_eq("issue_addr",   {24'd0, o_reg_addr}, {24'd0, r_addr[k]});
        check_eq("issue_data",   {24'd0, o_tx_data}, {24'd0, r_data[k]});
        check_eq("issue_busy",   {31'd0, o_busy}, 32'd1);
        m_ptr = (k + 1) % 3;
        exp_d = (jdone <= TO) ? jdone + 1 : TO + 1;
        got_d = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge i_clk);
            i_op_done = (c == jdone);
            i_rd_data = rdv;
            if (c == 1) check_eq("opcode_one_cycle", {30'd0, o_opcode}, 32'd0);
            if (got_d < 0) begin
                if ((o_done | o_err) != 3'b000) begin
                    got_d = c;
                    check_eq("complete_cycle", c, exp_d);
                    if (jdone <= TO) begin
                        if (!r_wr[k]) m_rd = rdv;
                        check_eq("done_pulse", {29'd0, o_done}, {29'd0, kmask});
                        check_eq("no_err",     {29'd0, o_err}, 32'd0);
                    end else begin
                        check_eq("no_done",    {29'd0, o_done}, 32'd0);
                        check_eq("err_pulse",  {29'd0, o_err}, {29'd0, kmask});
                    end
                    check_eq("grant_clear", {29'd0, o_grant}, 32'd0);
                    check_eq("rd_data", {24'd0, o_rd_data}, {24'd0, m_rd});
                    if (!hold) i_req[k] = 1'b0;
                end
            end else begin
                check_eq("gap_quiet", {29'd0, o_done | o_err}, 32'd0);
                if (c == got_d + GAP - 1) check_eq("gap_busy", {31'd0, o_busy}, 32'd1);
                if (c == got_d + GAP) begin
                    check_eq("idle_busy", {31'd0, o_busy}, 32'd0);
                    break;
                end
            end
        end
        i_op_done = 1'b0;
        if (got_d < 0) check_eq("completion_seen", got_d, exp_d);
    endtask

    initial begin
        int r;
        int jd;
        for (int k = 0; k < 3; k++) begin
            r_addr[k] = 8'h00;
            r_data[k] = 8'h00;
            r_wr[k]   = 1'b0;
        end
        #1;
        check_eq("reset_outputs",
                 {o_grant, o_done, o_err, o_opcode, o_busy, o_reg_addr, o_tx_data},
                 32'd0);
        check_eq("reset_rd_data", {24'd0, o_rd_data}, 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Single write, then a read, then a timeout with a late done in GAP.
        new_req(0, 1'b1, 8'h3D, 8'h0B);
        do_txn(10, 8'h00, 1'b0);
        new_req(1, 1'b0, 8'h1C, 8'h00);
        do_txn(6, 8'hA5, 1'b0);
        new_req(2, 1'b0, 8'h20, 8'h00);
        do_txn(23, 8'h77, 1'b0);

        // Fairness with all three requests held throughout.
        new_req(0, 1'b1, 8'h10, 8'h01);
        new_req(1, 1'b0, 8'h11, 8'h02);
        new_req(2, 1'b1, 8'h12, 8'h03);
        for (int t = 0; t < 6; t++) do_txn(3, 8'h40 + 8'(t), 1'b1);
        i_req = 3'b000;

        // Done on the very cycle the timeout would fire.
        new_req(0, 1'b0, 8'h08, 8'h00);
        do_txn(TO, 8'h5A, 1'b0);

        // Reset in the middle of WAIT; pointer is 1 before the reset.
        new_req(0, 1'b1, 8'h3B, 8'hC3);
        @(negedge i_clk);
        check_eq("pre_reset_grant", {29'd0, o_grant}, 32'd1);
        i_req = 3'b000;
        repeat (5) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check_eq("midreset_outputs",
                 {o_grant, o_done, o_err, o_opcode, o_busy, o_reg_addr, o_tx_data},
                 32'd0);
        check_eq("midreset_rd_data", {24'd0, o_rd_data}, 32'd0);
        m_ptr = 0;
        m_rd  = 8'h00;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        new_req(0, 1'b1, 8'h3D, 8'h00);
        new_req(1, 1'b0, 8'h3E, 8'h00);
        new_req(2, 1'b0, 8'h3F, 8'h00);
        do_txn(5, 8'h00, 1'b0);

        // Randomised traffic: new requests join at IDLE, mixed outcomes.
        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < 3; k++) begin
                if (!i_req[k] && $urandom_range(0, 1) == 1)
                    new_req(k, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            end
            if (i_req == 3'b000)
                new_req(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            r = int'($urandom_range(0, 7));
            if (r == 0)      jd = int'($urandom_range(TO + 1, TO + GAP));
            else if (r == 1) jd = TO;
            else             jd = int'($urandom_range(1, TO - 1));
            do_txn(jd, 8'($urandom), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bno055_txn_arbiter.md
BNO055_TXN_ARBITER -- requirements
Module: bno055_txn_arbiter

Interface
REQ-001 The block SHALL expose parameter TIMEOUT_CYCLES, default 24'd2500000, the maximum number of cycles to wait for i_op_done (100 ms at 25 MHz).
REQ-002 The block SHALL expose parameter GAP_CYCLES, default 24'd175000, the idle cycles enforced after every transaction (7 ms BNO055 mode-switch time).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 i_clk  in  1  system clock.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_req  in  3  per-requester level request; bit k belongs to requester k.
REQ-007 i_req_wr  in  3  per-requester direction: 1 = register write, 0 = register read.
REQ-008 i_req_addr  in  24  register address; requester k uses bits [8k+7:8k].
REQ-009 i_req_data  in  24  write data; requester k uses bits [8k+7:8k].
REQ-010 o_grant  out  3  one-hot; bit k high while requester k's transaction is in flight.
REQ-011 o_done  out  3  one-cycle pulse on bit k when requester k's transaction completes.
REQ-012 o_err  out  3  one-cycle pulse on bit k when requester k's transaction times out.
REQ-013 o_rd_data  out  8  read result; valid in the cycle o_done pulses for a read.
REQ-014 o_busy  out  1  high in every state except IDLE.
REQ-015 o_opcode  out  2  to the I2C engine: 0 = STOP, 1 = READ, 2 = WRITE.
REQ-016 o_reg_addr / o_tx_data  out  8 each  to the I2C engine.
REQ-017 i_op_done  in  1  engine completion pulse.
REQ-018 i_rd_data  in  8  engine read data; valid with i_op_done.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT and GAP.
REQ-020 All outputs SHALL be registered.
REQ-021 IDLE with any i_req bit set: select the winner round-robin, starting the search at pointer rr_ptr (the first set bit at or after rr_ptr, modulo 3).
REQ-022 On that IDLE cycle the block SHALL latch the winner's addr/data/wr into o_reg_addr, o_tx_data and an internal wr flag, set the winner's o_grant bit, and go to ISSUE.
REQ-023 After a grant to requester k, rr_ptr SHALL become (k+1) mod 3.
REQ-024 ISSUE: o_opcode SHALL be 2 if wr, else 1, for exactly one cycle; the block then goes to WAIT.
REQ-025 WAIT and all other states: o_opcode SHALL be 0.
REQ-026 WAIT: the timeout counter SHALL increment every cycle.
REQ-027 WAIT, on i_op_done: o_done[k] pulses; o_rd_data <= i_rd_data for reads (unchanged for writes); o_grant clears in the same cycle; the block goes to GAP.
REQ-028 WAIT, when the counter reaches TIMEOUT_CYCLES-1 without i_op_done: o_err[k] pulses, o_grant clears, no o_done is produced, and the block goes to GAP.
REQ-029 If i_op_done and the timeout occur in the same cycle, completion SHALL win: o_done pulses and o_err does not.
REQ-030 GAP SHALL last GAP_CYCLES cycles, then return to IDLE; GAP_CYCLES = 0 returns to IDLE on the next cycle.
REQ-031 i_op_done outside WAIT SHALL be ignored.
REQ-032 Requests arriving during ISSUE, WAIT or GAP SHALL wait; none are lost while held high.
REQ-033 A requester dropping i_req mid-transaction SHALL NOT abort the transaction; it still receives o_done or o_err.
REQ-034 Requesters SHALL drop i_req on the o_done/o_err cycle; a request still held is re-arbitrated as a new transaction.
REQ-035 Counters SHALL be 24 bits and reset to 0 on every state entry.

Reset
REQ-036 On i_rst_n low, asynchronously: state=IDLE, rr_ptr=0, o_grant=0, o_done=0, o_err=0, o_opcode=0, o_reg_addr=0, o_tx_data=0, o_rd_data=0, o_busy=0, counters=0.
REQ-037 A reset asserted mid-transaction SHALL abandon that transaction with no o_done or o_err; after release the block SHALL start in IDLE.

Verification (TIMEOUT_CYCLES=20, GAP_CYCLES=4 unless noted)
REQ-038 Single write: req0, wr=1, addr 0x3D, data 0x0B; engine asserts i_op_done 10 cycles later -> one cycle of o_opcode=2, o_grant=001, o_done=001 pulse, o_busy low exactly 4 cycles after done.
REQ-039 Read: req1, addr 0x1C; engine returns i_rd_data=0xA5 -> o_opcode=1 for one cycle, o_rd_data=0xA5 with o_done=010.
REQ-040 Fairness: i_req=111 held continuously -> grant order 0,1,2,0,1,2 across six transactions.
REQ-041 Timeout: req2 with no i_op_done -> o_err=100 at the 20th WAIT cycle and no o_done; a late i_op_done during GAP is ignored.
REQ-042 Tie: i_op_done on the timeout cycle -> o_done pulses, o_err stays 0.
REQ-043 Reset mid-WAIT -> all outputs 0 immediately; a new req0 after release -> rr_ptr=0 and grant=001.
